// File: rtl/mpu_alu_seq.sv
// Sequential lane ALU for the MPU: extracts b/w/dw/qw lanes from three operands and runs
// MASK/CMP/LT/ADD/HAMM with a valid/ready handshake on both sides.
module mpu_alu_seq #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned POP_W  = 8,
  localparam int unsigned SEL_W = $clog2(DATA_W / 8)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        size,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] o0,
  input  logic [DATA_W-1:0] o1,
  input  logic [DATA_W-1:0] o2,
  input  logic [SEL_W-1:0]  s0,
  input  logic [SEL_W-1:0]  s1,
  input  logic [SEL_W-1:0]  s2,
  input  logic [SEL_W-1:0]  sres,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic [7:0]        flags
);

  localparam logic [3:0] OpMask = 4'h0;
  localparam logic [3:0] OpCmp  = 4'h1;
  localparam logic [3:0] OpLt   = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpHamm = 4'h4;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StExtract = 2'd1;
  localparam logic [1:0] StExec    = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] o0_q, o1_q, o2_q;
  logic [SEL_W-1:0]  s0_q, s1_q, s2_q, sres_q;
  logic [63:0]       a_q, b_q, c_q, a_d, b_d, c_d;
  logic [63:0]       diff_q, diff_d;
  logic              err_q, err_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [7:0]        flags_q, flags_d;

  int unsigned       lane_bits;
  logic [63:0]       lane_mask;
  logic              err_c;
  logic [6:0]        iter_cnt;
  logic [7:0]        acc_sum;
  logic [64:0]       sum65;
  logic [63:0]       lane_res;
  logic              carry_c;

  function automatic logic [63:0] lane_of(logic [DATA_W-1:0] v, logic [SEL_W-1:0] s,
                                          int unsigned bits, logic [63:0] mask);
    logic [DATA_W-1:0] sh;
    sh = v >> (32'(s) * bits);
    return 64'(sh) & mask;
  endfunction

  function automatic logic sel_bad(logic [SEL_W-1:0] s, int unsigned bits);
    return ((32'(s) + 32'd1) * bits) > DATA_W;
  endfunction

  function automatic logic [7:0] popcnt(logic [POP_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < int'(POP_W); i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  assign in_ready  = (state_q == StIdle) & ~sys_rst;
  assign out_valid = (state_q == StDone);
  assign res       = res_q;
  assign flags     = flags_q;

  assign lane_bits = 32'd8 << size_q;
  assign lane_mask = (lane_bits == 32'd64) ? '1 : ((64'd1 << lane_bits) - 64'd1);

  assign err_c = (op_q > OpHamm) || (lane_bits > DATA_W) || sel_bad(s0_q, lane_bits) ||
                 sel_bad(s1_q, lane_bits) || sel_bad(s2_q, lane_bits) ||
                 sel_bad(sres_q, lane_bits);

  // Errors and non-HAMM ops take a single EXEC cycle.
  assign iter_cnt = (op_q == OpHamm && !err_c && lane_bits > POP_W) ?
                    7'(lane_bits / POP_W) : 7'd1;

  assign acc_sum = acc_q + popcnt(diff_q[POP_W-1:0]);
  assign sum65   = {1'b0, b_q} + {1'b0, c_q};

  always_comb begin
    lane_res = '0;
    carry_c  = 1'b0;
    case (op_q)
      OpMask: lane_res = {63'd0, (((~a_q & ~b_q) | (a_q & ~c_q)) & lane_mask) == 64'd0};
      OpCmp:  lane_res = {63'd0, (a_q & c_q) == (b_q & c_q)};
      OpLt:   lane_res = {63'd0, a_q < b_q};
      OpAdd: begin
        lane_res = sum65[63:0] & lane_mask;
        carry_c  = sum65[lane_bits[6:0]];
      end
      OpHamm: lane_res = {56'd0, acc_sum};
      default: lane_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    diff_d  = diff_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      StIdle: if (in_valid) state_d = StExtract;
      StExtract: begin
        a_d     = lane_of(o0_q, s0_q, lane_bits, lane_mask);
        b_d     = lane_of(o1_q, s1_q, lane_bits, lane_mask);
        c_d     = lane_of(o2_q, s2_q, lane_bits, lane_mask);
        diff_d  = b_d ^ c_d;
        err_d   = err_c;
        cnt_d   = iter_cnt;
        acc_d   = '0;
        state_d = StExec;
      end
      StExec: begin
        acc_d  = acc_sum;
        diff_d = diff_q >> POP_W;
        if (cnt_q == 7'd1) begin
          state_d = StDone;
          if (err_q) begin
            res_d   = '0;
            flags_d = 8'h04;
          end else begin
            res_d   = DATA_W'(lane_res) << (32'(sres_q) * lane_bits);
            flags_d = {6'd0, carry_c, lane_res == 64'd0};
          end
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      diff_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      diff_q  <= diff_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Request capture; these registers are don't-care outside an operation.
  always_ff @(posedge sys_clk) begin
    if (in_valid && in_ready) begin
      op_q   <= op;
      size_q <= size;
      o0_q   <= o0;
      o1_q   <= o1;
      o2_q   <= o2;
      s0_q   <= s0;
      s1_q   <= s1;
      s2_q   <= s2;
      sres_q <= sres;
    end
  end

endmodule
